// File: rtl/vga_sync_640x480.sv
// vga_sync_640x480 : VGA timing generator (default 640x480 @ 60 Hz, 800x525).
// Two free-running compare-and-clear counters (hc, vc) feed one output
// register stage, so every output shows the decode of the same hc/vc and
// all outputs stay coherent with a fixed 1-clock latency.
// Optional build macro VGA_TEST_PATTERN_EN adds a 12-bit rgb colour-bar output.
`timescale 1ns/1ps

module vga_sync_640x480 #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       clr_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0] rgb
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits wide; larger timings cannot be represented.
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_sync_640x480: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
  endgenerate

  // Decode limits kept one bit wider than the counters so that a boundary
  // equal to 1024 still compares correctly.
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS  = 11'(V_DISPLAY);
  localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_END = 11'(V_DISPLAY + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0]  BAR_W  = 10'(H_DISPLAY / 8);
`endif

  logic [9:0]  hc, vc;
  logic [10:0] hc_w, vc_w;
  logic        hs_act, vs_act, vis, sof;

  assign hc_w = {1'b0, hc};
  assign vc_w = {1'b0, vc};

  // Pixel/line counters: wrap by explicit compare-and-clear, vc steps on hc wrap.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // Timing decode of the current counter position (polarity-free).
  always_comb begin
    hs_act = 1'b0;
    vs_act = 1'b0;
    vis    = 1'b0;
    sof    = 1'b0;
    hs_act = (hc_w >= HS_BEG) && (hc_w < HS_END);
    vs_act = (vc_w >= VS_BEG) && (vc_w < VS_END);
    vis    = (hc_w < H_VIS) && (vc_w < V_VIS);
    sof    = (hc == '0) && (vc == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  bar;
  logic [11:0] bar_rgb;

  // Colour-bar lookup: eight equal-width bars across the visible line.
  always_comb begin
    bar     = 3'(hc / BAR_W);
    bar_rgb = 12'h000;
    if (vis) begin
      case (bar)
        3'd0:    bar_rgb = 12'hFFF;
        3'd1:    bar_rgb = 12'hFF0;
        3'd2:    bar_rgb = 12'h0FF;
        3'd3:    bar_rgb = 12'h0F0;
        3'd4:    bar_rgb = 12'hF0F;
        3'd5:    bar_rgb = 12'hF00;
        3'd6:    bar_rgb = 12'h00F;
        default: bar_rgb = 12'h000;
      endcase
    end
  end
`endif

  // Output register: sync polarity is applied only here, reset drives the
  // inactive level directly so an async reset never produces a sync pulse.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      rgb         <= 12'h000;
`endif
    end else begin
      hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
      video_on    <= vis;
      pixel_x     <= hc;
      pixel_y     <= vc;
      frame_start <= sof;
`ifdef VGA_TEST_PATTERN_EN
      rgb         <= bar_rgb;
`endif
    end
  end

endmodule

// File: tb/tb_vga_sync_640x480.sv
// Testbench for vga_sync_640x480: a default-timing instance plus a small
// timing instance (active-high sync) so full frames fit in a short run.
`timescale 1ns/1ps

module tb_vga_sync_640x480;

  localparam int SH_D = 32, SH_F = 4, SH_S = 6, SH_B = 5;
  localparam int SV_D = 12, SV_F = 2, SV_S = 2, SV_B = 3;
  localparam int SHT = SH_D + SH_F + SH_S + SH_B;
  localparam int SVT = SV_D + SV_F + SV_S + SV_B;
  localparam int SFRAME = SHT * SVT;
  localparam int NTR = 4000;

  logic clk = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  logic       hs_d, vs_d, von_d, fs_d, hs_s, vs_s, von_s, fs_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic [11:0] rgb_d, rgb_s;

  vga_sync_640x480 u_dflt (
    .clk(clk), .clr_n(clr_n), .hsync(hs_d), .vsync(vs_d), .video_on(von_d),
    .pixel_x(x_d), .pixel_y(y_d), .frame_start(fs_d)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(rgb_d)
`endif
  );

  vga_sync_640x480 #(
    .H_DISPLAY(SH_D), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_DISPLAY(SV_D), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .clr_n(clr_n), .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
    .pixel_x(x_s), .pixel_y(y_s), .frame_start(fs_s)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(rgb_s)
`endif
  );

`ifndef VGA_TEST_PATTERN_EN
  assign rgb_d = 12'h000;
  assign rgb_s = 12'h000;
`endif

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs, vs, von, fs;
  } vec_t;

  obs_t act_d, act_s;
  assign act_d = {x_d, y_d, hs_d, vs_d, von_d, fs_d, rgb_d};
  assign act_s = {x_s, y_s, hs_s, vs_s, von_s, fs_s, rgb_s};

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] bar_colour(input int b);
    case (b)
      0: return 12'hFFF;  1: return 12'hFF0;  2: return 12'h0FF;  3: return 12'h0F0;
      4: return 12'hF0F;  5: return 12'hF00;  6: return 12'h00F;  default: return 12'h000;
    endcase
  endfunction

  // Reference: output after kk clock edges since reset release shows raster
  // position kk-1 of a frame laid out as V_TOTAL lines of H_TOTAL pixels.
  function automatic obs_t model(input int hd, hf, hsw, hb, vd, vf, vsw, vb,
                                 input bit pol, input int kk);
    obs_t o;
    int ht, vt, p, x, y;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    o = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    if (kk == 0) return o;
    p = (kk - 1) % (ht * vt);
    x = p % ht;
    y = p / ht;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.von = (x < hd) && (y < vd);
    o.hs  = (x >= hd + hf && x < hd + hf + hsw) ? pol : ~pol;
    o.vs  = (y >= vd + vf && y < vd + vf + vsw) ? pol : ~pol;
    o.fs  = (p == 0);
`ifdef VGA_TEST_PATTERN_EN
    if (o.von) o.rgb = bar_colour(x / (hd / 8));
`endif
    return o;
  endfunction

  // Edges seen since the last reset release.
  int k = 0;
  always @(posedge clk or negedge clr_n)
    if (!clr_n) k <= 0;
    else        k <= k + 1;

  bit sb_en = 1'b0;
  always @(negedge clk)
    if (sb_en) begin
      chk("sb_default", act_d, model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, k));
      chk("sb_small",   act_s, model(SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b1, k));
    end

  bit rec_en = 1'b0;
  obs_t tr_d[$], tr_s[$];
  always @(negedge clk)
    if (rec_en) begin
      tr_d.push_back(act_d);
      tr_s.push_back(act_s);
    end

  task automatic chk_rst(input string nm);
    obs_t ed, es;
    ed = '0; ed.hs = 1'b1; ed.vs = 1'b1;
    es = '0;
    chk({nm, "_dflt"}, act_d, ed);
    chk({nm, "_small"}, act_s, es);
  endtask

  vec_t vecs[12];
  int   g, cnt, first, maxy, wraps, n;
  int   edges[$];

  initial begin
    vecs[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{640,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{641,  10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{656,  10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{657,  10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{752,  10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{753,  10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{800,  10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{801,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1441, 10'd640, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1457, 10'd656, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held for 10 clocks.
    #1 clr_n = 1'b0;
    repeat (10) @(negedge clk);
    chk_rst("reset_hold");
    sb_en = 1'b1;

    // Release and record the first NTR output cycles.
    @(negedge clk) clr_n = 1'b1;
    @(posedge clk); #1 rec_en = 1'b1;

    foreach (vecs[i]) begin
      g = 0;
      do begin @(negedge clk); g++; end while (k < vecs[i].k && g < 5000);
      chk($sformatf("vec%0d_k", i), 64'(k), 64'(vecs[i].k));
      chk($sformatf("vec%0d_out", i), {x_d, y_d, hs_d, vs_d, von_d, fs_d},
          {vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].von, vecs[i].fs});
    end

    g = 0;
    while (tr_d.size() < NTR && g < 2 * NTR) begin @(posedge clk); g++; end
    rec_en = 1'b0;
    chk("trace_len", 64'(tr_d.size()), 64'(NTR));

    if (tr_d.size() >= NTR) begin
      // Default: horizontal timing on line 1 and across the trace.
      cnt = 0; first = -1;
      for (int i = 800; i < 1600; i++)
        if (!tr_d[i].hs) begin cnt++; if (first < 0) first = tr_d[i].x; end
      chk("h_sync_width", 64'(cnt), 64'(96));
      chk("h_sync_start_x", 64'(first), 64'(656));
      edges.delete();
      for (int i = 1; i < NTR; i++)
        if (tr_d[i-1].hs && !tr_d[i].hs) edges.push_back(i);
      chk("h_fall_count", 64'(edges.size()), 64'(5));
      for (int j = 1; j < edges.size(); j++)
        chk("h_fall_period", 64'(edges[j] - edges[j-1]), 64'(800));
      cnt = 0;
      for (int i = 0; i < 800; i++) if (tr_d[i].von) cnt++;
      chk("h_video_on_count", 64'(cnt), 64'(640));

      // Small instance: vertical timing, frame period, wrap.
      cnt = 0; first = -1;
      for (int i = 0; i < SFRAME; i++)
        if (tr_s[i].vs) begin cnt++; if (first < 0) first = i; end
      chk("v_sync_width", 64'(cnt), 64'(SV_S * SHT));
      if (first >= 0) chk("v_sync_start", {tr_s[first].x, tr_s[first].y}, {10'd0, 10'(SV_D + SV_F)});
      edges.delete();
      for (int i = 0; i < NTR; i++) if (tr_s[i].fs) edges.push_back(i);
      chk("frame_start_count", 64'(edges.size()), 64'((NTR - 1) / SFRAME + 1));
      for (int j = 1; j < edges.size(); j++)
        chk("frame_period", 64'(edges[j] - edges[j-1]), 64'(SFRAME));
      cnt = 0;
      for (int i = 0; i < SFRAME; i++) if (tr_s[i].von) cnt++;
      chk("v_video_on_count", 64'(cnt), 64'(SH_D * SV_D));
      cnt = 0;
      for (int i = SHT; i < 2 * SHT; i++) if (tr_s[i].hs) cnt++;
      chk("small_hsync_width", 64'(cnt), 64'(SH_S));
      maxy = 0; wraps = 0;
      for (int i = 0; i < NTR; i++) begin
        if (tr_s[i].y > maxy) maxy = tr_s[i].y;
        if (i + 1 < NTR && tr_s[i].x == SHT - 1 && tr_s[i].y == SVT - 1) begin
          wraps++;
          chk("wrap_next", {tr_s[i+1].x, tr_s[i+1].y, tr_s[i+1].fs}, {10'd0, 10'd0, 1'b1});
        end
      end
      chk("max_pixel_y", 64'(maxy), 64'(SVT - 1));
      chk("wrap_seen", 64'(wraps > 0), 64'(1));

`ifdef VGA_TEST_PATTERN_EN
      chk("rgb_x79",  tr_d[79].rgb,  12'hFFF);
      chk("rgb_x80",  tr_d[80].rgb,  12'hFF0);
      chk("rgb_x639", tr_d[639].rgb, 12'h000);
      chk("rgb_x640", tr_d[640].rgb, 12'h000);
      chk("rgb_small_bar1", tr_s[SH_D / 8].rgb, 12'hFF0);
      chk("rgb_small_y_blank", tr_s[SHT * SV_D].rgb, 12'h000);
`endif
    end

    // Mid-frame asynchronous reset while the default hsync is active.
    g = 0;
    do begin @(negedge clk); g++; end while (x_d != 10'd700 && g < 2000);
    chk("mid_wait_x700", 64'(x_d), 64'(700));
    chk("mid_in_hsync", 64'(hs_d), 64'(0));
    @(posedge clk); #2 clr_n = 1'b0;
    #1 chk_rst("mid_reset_immediate");
    repeat (3) @(negedge clk);
    chk_rst("mid_reset_hold");
    clr_n = 1'b1;
    @(negedge clk);
    chk("mid_restart_dflt", {x_d, y_d, von_d, fs_d}, {10'd0, 10'd0, 1'b1, 1'b1});
    chk("mid_restart_small", {x_s, y_s, von_s, fs_s}, {10'd0, 10'd0, 1'b1, 1'b1});
    n = 0;
    do begin @(negedge clk); n++; end while (!fs_s && n < 3 * SFRAME);
    chk("mid_next_frame_start", 64'(n), 64'(SFRAME));

    // Random async resets at random points, scoreboard running throughout.
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(2500, 50);
      repeat (n) @(negedge clk);
      @(posedge clk);
      #($urandom_range(3, 1));
      clr_n = 1'b0;
      #1 chk_rst($sformatf("rand_reset%0d", it));
      repeat ($urandom_range(4, 1)) @(negedge clk);
      clr_n = 1'b1;
    end
    repeat (1000) @(negedge clk);
    sb_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
